// File: rtl/sdram_arbiter.sv
// Access scheduler for the SDRAM command bus: owns the auto-refresh timer and
// grants the bus to the refresh, write-burst or read-burst engine.
module sdram_arbiter #(
  parameter int REF_PERIOD = 1040,
  parameter int CNT_W      = 11
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic       init_done,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic       ref_done,
  input  logic       wr_done,
  input  logic       rd_done,
  output logic       ref_en,
  output logic       wr_en,
  output logic       rd_en,
  output logic       ref_pending,
  output logic       ref_overrun,
  output logic [4:0] state_o
);

  typedef enum logic [4:0] {
    WAIT_INIT = 5'b00001,
    ARB       = 5'b00010,
    AREF      = 5'b00100,
    WRITE     = 5'b01000,
    READ      = 5'b10000
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REF_PERIOD - 1);

  state_t           state;
  logic [CNT_W-1:0] ref_cnt;
  logic             last_wr;   // 1: last data grant was WRITE, 0: READ
  logic             expire;

  assign expire = (state != WAIT_INIT) && (ref_cnt == CNT_MAX);

  // Grants are single flop bits of the one-hot state register.
  assign ref_en  = state[2];
  assign wr_en   = state[3];
  assign rd_en   = state[4];
  assign state_o = state;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_INIT;
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
      ref_overrun <= 1'b0;
      last_wr     <= 1'b0;
    end else if (!init_done) begin
      state       <= WAIT_INIT;
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
    end else begin
      if (state != WAIT_INIT)
        ref_cnt <= expire ? '0 : ref_cnt + 1'b1;

      // A new expiry beats the clear from ref_done on the same edge.
      if (expire) begin
        ref_pending <= 1'b1;
        if (ref_pending)
          ref_overrun <= 1'b1;
      end else if (state == AREF && ref_done) begin
        ref_pending <= 1'b0;
      end

      unique case (state)
        WAIT_INIT: state <= ARB;
        ARB: begin
          if (ref_pending) begin
            state <= AREF;
          end else if (wr_req && (!rd_req || !last_wr)) begin
            state   <= WRITE;
            last_wr <= 1'b1;
          end else if (rd_req) begin
            state   <= READ;
            last_wr <= 1'b0;
          end
        end
        AREF:  if (ref_done) state <= ARB;
        WRITE: if (wr_done)  state <= ARB;
        READ:  if (rd_done)  state <= ARB;
        default: state <= WAIT_INIT;
      endcase
    end
  end

endmodule
